// File: rtl/jtpang_pkg.sv
// jtpang_pkg: constants and state encoding shared by the object DMA
// and its neighbours on the CPU/video bus.
package jtpang_pkg;

   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_REQ,
      DMA_XFER,
      DMA_FLUSH,
      DMA_DONE
   } dma_st_t;

   localparam logic [8:0] DMA_LEN_DEF = 9'd384;

   // bus handshake polarities
   localparam logic BUSRQ_ON = 1'b1;
   localparam logic BUSAK_ON = 1'b0;

endpackage

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: copies the VRAM object table into the sprite buffer.
// Optional macro JTPANG_DMA_VBLANK_EN: transfers only start during vblank.
module jtpang_objdma
   import jtpang_pkg::*;
#(
   parameter int AW = 9,
   parameter logic [AW-1:0] DMA_LEN = AW'(DMA_LEN_DEF)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          LVBL,
   input  logic          dma_go,
   input  logic          busak_n,
   output logic          busrq,
   output logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_din,
   output logic [AW-1:0] buf_addr,
   output logic [7:0]    buf_din,
   output logic          buf_we,
   output logic          busy
);

   localparam logic [AW-1:0] LAST = DMA_LEN - 1'b1;

   dma_st_t    st;
   logic       go_l;
   logic       pending;
   logic       hold;
   logic       first;
   logic [7:0] pipe;
   logic       trig;
   logic       ack;
   logic       start_ok;
   logic [7:0] rd_byte;

   assign trig    = dma_go & ~go_l;
   assign ack     = busak_n == BUSAK_ON;
   // after a freeze the byte latched at freeze time is the valid one
   assign rd_byte = hold ? pipe : dma_din;

`ifdef JTPANG_DMA_VBLANK_EN
   assign start_ok = ~LVBL;
`else
   logic unused_lvbl;
   assign unused_lvbl = LVBL;
   assign start_ok    = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= DMA_IDLE;
         busrq    <= ~BUSRQ_ON;
         busy     <= 1'b0;
         buf_we   <= 1'b0;
         dma_addr <= '0;
         buf_addr <= '0;
         buf_din  <= '0;
         pending  <= 1'b0;
         // high so a dma_go held across reset release is no edge
         go_l     <= 1'b1;
         hold     <= 1'b0;
         first    <= 1'b0;
         pipe     <= '0;
      end else begin
         go_l   <= dma_go;
         buf_we <= 1'b0;
         unique case (st)
            DMA_IDLE: begin
               if (trig || pending) begin
                  if (start_ok) begin
                     st       <= DMA_REQ;
                     busrq    <= BUSRQ_ON;
                     busy     <= 1'b1;
                     dma_addr <= '0;
                     pending  <= 1'b0;
                  end else begin
                     pending <= 1'b1;
                  end
               end
            end
            DMA_REQ: begin
               if (trig) pending <= 1'b1;
               if (cen && ack) begin
                  st    <= DMA_XFER;
                  first <= 1'b1;
                  hold  <= 1'b0;
               end
            end
            DMA_XFER, DMA_FLUSH: begin
               if (trig) pending <= 1'b1;
               if (cen) begin
                  if (!ack) begin
                     if (!hold) begin
                        pipe <= dma_din;
                        hold <= 1'b1;
                     end
                  end else begin
                     hold <= 1'b0;
                     if (st == DMA_FLUSH) begin
                        buf_we   <= 1'b1;
                        buf_addr <= LAST;
                        buf_din  <= rd_byte;
                        st       <= DMA_DONE;
                     end else begin
                        first <= 1'b0;
                        if (!first) begin
                           buf_we   <= 1'b1;
                           buf_addr <= dma_addr - 1'b1;
                           buf_din  <= rd_byte;
                        end
                        if (dma_addr == LAST) begin
                           st <= DMA_FLUSH;
                        end else begin
                           dma_addr <= dma_addr + 1'b1;
                        end
                     end
                  end
               end
            end
            DMA_DONE: begin
               busrq <= ~BUSRQ_ON;
               busy  <= 1'b0;
               st    <= DMA_IDLE;
               if (trig) pending <= 1'b1;
            end
            default: st <= DMA_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtpang_objdma.sv
// tb_jtpang_objdma: random-paced scoreboard bench for the object DMA.
// Expected writes come from a VRAM image; a monitor checks each buf_we.
module tb_jtpang_objdma;

   localparam int LEN = 384;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cen = 1'b0;
   logic       LVBL = 1'b0;
   logic       dma_go = 1'b0;
   logic       busak_n = 1'b1;
   logic [7:0] dma_din = 8'd0;
   logic       busrq, busy, buf_we;
   logic [8:0] dma_addr, buf_addr;
   logic [7:0] buf_din;

   int checks = 0;
   int errors = 0;
   int nwr = 0;
   int ack_dly = 3;
   int ack_wait = 0;
   int frz_cnt = 0;

   logic [7:0]  mem [LEN];
   logic [16:0] exp_q [$];
   logic        ak_s = 1'b1;
   logic        cen_s = 1'b0;

   always #10 clk = ~clk;

   jtpang_objdma dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .LVBL     (LVBL),
      .dma_go   (dma_go),
      .busak_n  (busak_n),
      .busrq    (busrq),
      .dma_addr (dma_addr),
      .dma_din  (dma_din),
      .buf_addr (buf_addr),
      .buf_din  (buf_din),
      .buf_we   (buf_we),
      .busy     (busy)
   );

   // VRAM: data for the address presented at one cen appears at the next
   always @(posedge clk) begin
      if (cen && dma_addr < 9'(LEN)) dma_din <= mem[dma_addr];
      ak_s  <= busak_n;
      cen_s <= cen;
   end

   // cen pacing and CPU bus acknowledge
   initial begin
      forever begin
         @(negedge clk);
         cen = ($urandom % 2) == 0;
         if (frz_cnt > 0) begin
            busak_n = 1'b1;
            if (cen) frz_cnt--;
         end else if (!busrq) begin
            busak_n  = 1'b1;
            ack_wait = 0;
         end else if (busak_n) begin
            if (cen) ack_wait++;
            if (ack_wait > ack_dly) busak_n = 1'b0;
         end
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && buf_we) begin
         logic [16:0] e;
         nwr++;
         checks++;
         if (ak_s || !cen_s) begin
            errors++;
            $display("FAIL write_qual busak_n=%b cen=%b", ak_s, cen_s);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h",
                     buf_addr, buf_din);
         end else begin
            e = exp_q.pop_front();
            if ({buf_addr, buf_din} !== e) begin
               errors++;
               $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                        buf_addr, buf_din, e[16:8], e[7:0]);
            end
         end
      end
      if (rst_n && dma_addr >= 9'(LEN)) begin
         checks++;
         errors++;
         $display("FAIL addr_range dma_addr=%0d max=%0d", dma_addr, LEN-1);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic new_image();
      for (int i = 0; i < LEN; i++) mem[i] = 8'($urandom);
   endtask

   task automatic expect_xfer();
      for (int i = 0; i < LEN; i++) exp_q.push_back({9'(i), mem[i]});
   endtask

   task automatic trigger();
      @(negedge clk);
      dma_go = 1'b1;
      @(negedge clk);
      dma_go = 1'b0;
   endtask

   task automatic wait_writes(input int n, input string name);
      int i;
      for (i = 0; i < 4000 && nwr < n; i++) @(negedge clk);
      if (nwr < n) chk(name, nwr, n);
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && !busrq) break;
      end
      chk({name, "_idle"}, int'(busy || busrq || exp_q.size() != 0), 0);
   endtask

   initial begin
      int w0;
      int i;
      logic bad;
      new_image();
      repeat (3) @(negedge clk);
      chk("rst_busrq", busrq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we", buf_we, 0);
      chk("rst_dma_addr", dma_addr, 0);
      chk("rst_buf_addr", buf_addr, 0);
      chk("rst_buf_din", buf_din, 0);
      rst_n = 1'b1;

      // 1: plain transfer
      w0 = nwr;
      @(negedge clk);
      expect_xfer();
      dma_go = 1'b1;
      @(negedge clk);
      chk("t1_busrq_rise", busrq, 1);
      chk("t1_busy_rise", busy, 1);
      dma_go = 1'b0;
      wait_idle("t1");
      chk("t1_writes", nwr - w0, LEN);

      // 2: bus taken back mid-transfer
      new_image();
      ack_dly = $urandom_range(4, 1);
      w0 = nwr;
      expect_xfer();
      trigger();
      for (i = 0; i < 4000 && dma_addr != 9'd100; i++) @(negedge clk);
      chk("t2_reach_100", dma_addr, 100);
      frz_cnt = 10;
      @(negedge clk);
      @(negedge clk);
      w0 = nwr;
      bad = 1'b0;
      for (i = 0; i < 400 && frz_cnt > 0; i++) begin
         @(negedge clk);
         if (!busrq) bad = 1'b1;
      end
      chk("t2_frz_end", frz_cnt, 0);
      chk("t2_frz_no_we", nwr - w0, 0);
      chk("t2_frz_busrq", bad, 0);
      wait_idle("t2");

      // 3: retrigger while busy, extra edges merge
      new_image();
      w0 = nwr;
      expect_xfer();
      trigger();
      wait_writes(w0 + 200, "t3_w200");
      expect_xfer();
      trigger();
      wait_writes(w0 + 250, "t3_w250");
      trigger();
      for (i = 0; i < 4000 && busrq; i++) @(negedge clk);
      chk("t3_busrq_drop", busrq, 0);
      @(negedge clk);
      chk("t3_busrq_back", busrq, 1);
      wait_idle("t3");
      chk("t3_writes", nwr - w0, 2 * LEN);

      // 4: reset mid-transfer
      w0 = nwr;
      expect_xfer();
      trigger();
      wait_writes(w0 + 50, "t4_w50");
      rst_n = 1'b0;
      #1;
      chk("t4_busrq", busrq, 0);
      chk("t4_busy", busy, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("t4_stays_idle", busrq, 0);

      // 5: trigger during active video
      new_image();
      w0 = nwr;
      LVBL = 1'b1;
      expect_xfer();
      trigger();
`ifdef JTPANG_DMA_VBLANK_EN
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (busrq) bad = 1'b1;
      end
      chk("t5_wait_vblank", bad, 0);
      LVBL = 1'b0;
      @(negedge clk);
      chk("t5_busrq_rise", busrq, 1);
      wait_writes(w0 + 100, "t5_w100");
      LVBL = 1'b1;
`else
      chk("t5_lvbl_ignored", busrq, 1);
`endif
      wait_idle("t5");
      chk("t5_writes", nwr - w0, LEN);
      LVBL = 1'b0;

      // 6: level held at reset release, then a long pulse
      rst_n = 1'b0;
      dma_go = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_rst_release", busrq, 0);
      dma_go = 1'b0;
      @(negedge clk);
      w0 = nwr;
      expect_xfer();
      dma_go = 1'b1;
      repeat (2000) @(negedge clk);
      wait_idle("t6");
      chk("t6_writes", nwr - w0, LEN);
      dma_go = 1'b0;
      repeat (10) @(negedge clk);

      chk("final_queue", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
